// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the fetch port and the load/store port.
// Data requests win, but a pending fetch is served after DATA_BURST data grants. Stalled accesses time out.
module mem_port_arbiter #(
    parameter int unsigned DATA_BURST = 4,
    parameter int unsigned TIMEOUT    = 15,
    parameter logic [31:0] ABORT_DATA = 32'hDEADBEEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        stall_if,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_valid,
    output logic        stall_mem,
    output logic        ram_en,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ready,
    output logic        bus_err
);
    localparam int BURST_W = $clog2(DATA_BURST + 1);
    localparam int WAIT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, IF_ACC, DATA_ACC} state_t;

    state_t               state, state_nxt;
    logic [BURST_W-1:0]   burst_cnt, burst_nxt;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [31:0]          lat_addr, lat_wdata;
    logic                 lat_we;
    logic                 access, timeout_hit, done, arb;
    logic                 data_req, grant_if, grant_data;

    assign access      = (state != IDLE);
    assign timeout_hit = access && !ram_ready && (wait_cnt == WAIT_W'(TIMEOUT - 1));
    assign done        = access && (ram_ready || timeout_hit);
    assign arb         = (state == IDLE) || done;
    assign data_req    = mem_rd | mem_wr;

    always_comb begin
        state_nxt  = state;
        burst_nxt  = burst_cnt;
        grant_if   = 1'b0;
        grant_data = 1'b0;
        if (arb) begin
            if (if_req && (!data_req || burst_cnt == BURST_W'(DATA_BURST))) begin
                state_nxt = IF_ACC;
                grant_if  = 1'b1;
                burst_nxt = '0;
            end else if (data_req) begin
                state_nxt  = DATA_ACC;
                grant_data = 1'b1;
                // Only data grants that make a fetch wait count toward the burst limit.
                burst_nxt  = if_req ? burst_cnt + 1'b1 : '0;
            end else begin
                state_nxt = IDLE;
                burst_nxt = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            burst_cnt <= '0;
            wait_cnt  <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            if_valid  <= 1'b0;
            mem_valid <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            bus_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
            if_valid  <= done && (state == IF_ACC);
            mem_valid <= done && (state == DATA_ACC);

            if (done && state == IF_ACC)
                if_rdata <= timeout_hit ? ABORT_DATA : ram_rdata;
            if (done && state == DATA_ACC && !lat_we)
                mem_rdata <= timeout_hit ? ABORT_DATA : ram_rdata;
            if (timeout_hit)
                bus_err <= 1'b1;

            if (arb)
                wait_cnt <= '0;
            else if (!ram_ready)
                wait_cnt <= wait_cnt + 1'b1;

            // A simultaneous read and write is treated as a write.
            if (grant_if) begin
                lat_addr  <= if_addr;
                lat_wdata <= '0;
                lat_we    <= 1'b0;
            end else if (grant_data) begin
                lat_addr  <= mem_addr;
                lat_wdata <= mem_wdata;
                lat_we    <= mem_wr;
            end
        end
    end

    assign ram_en    = access;
    assign ram_we    = access && lat_we;
    assign ram_addr  = lat_addr;
    assign ram_wdata = lat_wdata;
    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = (mem_rd | mem_wr) & ~mem_valid;

endmodule
